// File: rtl/multiplier_if.sv
// multiplier_if - operand/result bundle for the iterative multiplier.
// Build option: none (the saturation option lives in multiplier.sv).
// Ports (signals carried):
//   multiplicand_in  master->slave  WIDTH     signed operand A
//   multiplier_in    master->slave  WIDTH     signed operand B
//   data_valid_in    master->slave  1         start request
//   product_out      slave->master  OUT_SIZE  signed product
//   data_valid_out   slave->master  1         one-cycle result strobe
//   overflow_out     slave->master  1         product did not fit OUT_SIZE
//   busy_out         slave->master  1         operation in flight
interface multiplier_if #(
   parameter int WIDTH    = 32,
   parameter int OUT_SIZE = 8
);
   logic signed [WIDTH-1:0]    multiplicand_in;
   logic signed [WIDTH-1:0]    multiplier_in;
   logic                       data_valid_in;
   logic signed [OUT_SIZE-1:0] product_out;
   logic                       data_valid_out;
   logic                       overflow_out;
   logic                       busy_out;

   modport master (
      output multiplicand_in, multiplier_in, data_valid_in,
      input  product_out, data_valid_out, overflow_out, busy_out
   );

   modport slave (
      input  multiplicand_in, multiplier_in, data_valid_in,
      output product_out, data_valid_out, overflow_out, busy_out
   );
endinterface

// File: rtl/multiplier.sv
// multiplier - iterative signed shift-add multiplier, one multiplier bit per
// clock, fixed latency of WIDTH+2 clocks from accept to data_valid_out.
// Shares the valid/busy handshake of the sequential divider.
// Build option: `define MULTIPLIER_SATURATE_EN to clamp overflowing products
// to the OUT_SIZE signed range; otherwise the product wraps (truncation).
// overflow_out is identical in both builds.
// Ports:
//   clk_in   in  system clock, posedge
//   rst_in   in  synchronous reset, active-high
//   mul_if   slave modport of multiplier_if (operands, start, product,
//            overflow, result strobe, busy)
module multiplier #(
   parameter int WIDTH    = 32,
   parameter int OUT_SIZE = 8
) (
   input  logic          clk_in,
   input  logic          rst_in,
   multiplier_if.slave   mul_if
);
   localparam int AW = 2 * WIDTH;
   localparam int PW = AW + 1;
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
   localparam logic signed [PW-1:0] P_MAX =
      {{(PW - OUT_SIZE + 1){1'b0}}, {(OUT_SIZE - 1){1'b1}}};
   localparam logic signed [PW-1:0] P_MIN = ~P_MAX;
   localparam logic [OUT_SIZE-1:0] SAT_MAX = {1'b0, {(OUT_SIZE - 1){1'b1}}};
   localparam logic [OUT_SIZE-1:0] SAT_MIN = {1'b1, {(OUT_SIZE - 1){1'b0}}};

   typedef enum logic [1:0] {
      RESTING,
      MULTIPLYING,
      SIGN,
      RESULT
   } state_e;

   state_e              state_q, state_d;
   logic [AW-1:0]       mcand_q, mcand_d;
   logic [WIDTH-1:0]    mplier_q, mplier_d;
   logic [AW-1:0]       acc_q, acc_d;
   logic [CW-1:0]       count_q, count_d;
   logic                neg_q, neg_d;
   logic [OUT_SIZE-1:0] res_q, res_d;
   logic                ovf_q, ovf_d;
   logic [OUT_SIZE-1:0] product_q, product_d;
   logic                valid_q, valid_d;
   logic                ovf_out_q, ovf_out_d;
   logic                busy_q, busy_d;

   logic [WIDTH-1:0]    a_raw, b_raw;
   logic [WIDTH-1:0]    abs_a, abs_b;
   logic [PW-1:0]       acc_ext;
   logic signed [PW-1:0] p_c;
   logic                p_ovf;

   // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), exact unsigned.
   always_comb begin
      a_raw = mul_if.multiplicand_in;
      b_raw = mul_if.multiplier_in;
      abs_a = a_raw[WIDTH-1] ? ('0 - a_raw) : a_raw;
      abs_b = b_raw[WIDTH-1] ? ('0 - b_raw) : b_raw;
   end

   // Signed product and range check, used in the SIGN state.
   always_comb begin
      acc_ext = {1'b0, acc_q};
      p_c     = neg_q ? ('0 - acc_ext) : acc_ext;
      p_ovf   = (p_c > P_MAX) || (p_c < P_MIN);
   end

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      count_d   = count_q;
      neg_d     = neg_q;
      res_d     = res_q;
      ovf_d     = ovf_q;
      product_d = product_q;
      valid_d   = 1'b0;
      ovf_out_d = ovf_out_q;
      busy_d    = busy_q;

      unique case (state_q)
         RESTING: begin
            if (mul_if.data_valid_in) begin
               mcand_d  = AW'(abs_a);
               mplier_d = abs_b;
               neg_d    = a_raw[WIDTH-1] ^ b_raw[WIDTH-1];
               acc_d    = '0;
               count_d  = '0;
               busy_d   = 1'b1;
               state_d  = MULTIPLYING;
            end
         end
         MULTIPLYING: begin
            // mcand_q is |A| pre-shifted by count_q, avoiding a barrel shifter.
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CW'(1);
            if (count_q == LAST_BIT) begin
               state_d = SIGN;
            end
         end
         SIGN: begin
            ovf_d = p_ovf;
`ifdef MULTIPLIER_SATURATE_EN
            if (p_ovf) begin
               res_d = p_c[PW-1] ? SAT_MIN : SAT_MAX;
            end else begin
               res_d = p_c[OUT_SIZE-1:0];
            end
`else
            res_d = p_c[OUT_SIZE-1:0];
`endif
            busy_d  = 1'b0;
            state_d = RESULT;
         end
         RESULT: begin
            product_d = res_q;
            ovf_out_d = ovf_q;
            valid_d   = 1'b1;
            state_d   = RESTING;
         end
         default: begin
            state_d = RESTING;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= RESTING;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         count_q   <= '0;
         neg_q     <= 1'b0;
         res_q     <= '0;
         ovf_q     <= 1'b0;
         product_q <= '0;
         valid_q   <= 1'b0;
         ovf_out_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         count_q   <= count_d;
         neg_q     <= neg_d;
         res_q     <= res_d;
         ovf_q     <= ovf_d;
         product_q <= product_d;
         valid_q   <= valid_d;
         ovf_out_q <= ovf_out_d;
         busy_q    <= busy_d;
      end
   end

   assign mul_if.product_out    = product_q;
   assign mul_if.data_valid_out = valid_q;
   assign mul_if.overflow_out   = ovf_out_q;
   assign mul_if.busy_out       = busy_q;
endmodule

// File: tb/tb_multiplier.sv
// tb_multiplier - directed tests for multiplier at WIDTH=32, OUT_SIZE=8.
// Honours MULTIPLIER_SATURATE_EN for the expected overflow products.
module tb_multiplier;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   errors  = 0;

   multiplier_if #(.WIDTH(32), .OUT_SIZE(8)) mul_if ();

   multiplier #(.WIDTH(32), .OUT_SIZE(8)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .mul_if (mul_if)
   );

   always #5 clk = ~clk;

   // Caller is at #1 after a posedge; the next posedge is the accept edge.
   task automatic start(input int a, input int b);
      mul_if.multiplicand_in = a;
      mul_if.multiplier_in   = b;
      mul_if.data_valid_in   = 1'b1;
      @(posedge clk); #1;
      mul_if.data_valid_in   = 1'b0;
   endtask

   // Waits for data_valid_out; lat counts edges since accept, busy counts
   // sampled cycles with busy_out high. Optionally injects a pulse at inj_at.
   task automatic wait_result(input int inj_at, output logic signed [7:0] p,
                              output logic ovf, output int lat,
                              output int busy, output bit got);
      lat = 0; busy = 0; got = 0; p = '0; ovf = 1'b0;
      while (lat < 100) begin
         if (mul_if.busy_out) busy++;
         if (mul_if.data_valid_out) begin
            got = 1; p = mul_if.product_out; ovf = mul_if.overflow_out;
            break;
         end
         if (lat == inj_at) begin
            mul_if.multiplicand_in = 5;
            mul_if.multiplier_in   = 5;
            mul_if.data_valid_in   = 1'b1;
         end
         if (lat == inj_at + 1) mul_if.data_valid_in = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic count_valids(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (mul_if.data_valid_out) cnt++;
      end
   endtask

   task automatic check_result(input string name, input int a, input int b,
                               input int exp_p, input logic exp_ovf);
      logic signed [7:0] p, e;
      logic ovf;
      int lat, busy;
      bit got;
      e = 8'(exp_p);
      start(a, b);
      wait_result(-10, p, ovf, lat, busy, got);
      vectors++;
      if (!got) begin
         errors++; $display("FAIL %s: no data_valid_out within 100 clocks", name);
      end else begin
         if (p !== e) begin
            errors++; $display("FAIL %s product: got %0d expected %0d", name, p, e);
         end
         vectors++;
         if (ovf !== exp_ovf) begin
            errors++; $display("FAIL %s overflow: got %0b expected %0b", name, ovf, exp_ovf);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mul_if.multiplicand_in = 3;
      mul_if.multiplier_in   = 3;
      mul_if.data_valid_in   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (mul_if.busy_out !== 1'b0) begin
         errors++; $display("FAIL reset busy: got %0b expected 0", mul_if.busy_out);
      end
      vectors++;
      if (mul_if.product_out !== 8'sd0) begin
         errors++; $display("FAIL reset product: got %0d expected 0", mul_if.product_out);
      end
      vectors++;
      if (mul_if.data_valid_out !== 1'b0) begin
         errors++; $display("FAIL reset valid: got %0b expected 0", mul_if.data_valid_out);
      end
      vectors++;
      if (mul_if.overflow_out !== 1'b0) begin
         errors++; $display("FAIL reset overflow: got %0b expected 0", mul_if.overflow_out);
      end
      mul_if.data_valid_in = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic signed [7:0] p;
      logic ovf;
      int lat, busy;
      bit got;
      start(12, 10);
      wait_result(-10, p, ovf, lat, busy, got);
      vectors++;
      if (!got || p !== 8'sd120) begin
         errors++; $display("FAIL 12x10 product: got %0d (valid %0b) expected 120", p, got);
      end
      vectors++;
      if (ovf !== 1'b0) begin
         errors++; $display("FAIL 12x10 overflow: got %0b expected 0", ovf);
      end
      vectors++;
      if (lat !== 34) begin
         errors++; $display("FAIL 12x10 latency: got %0d expected 34", lat);
      end
      vectors++;
      if (busy !== 33) begin
         errors++; $display("FAIL 12x10 busy cycles: got %0d expected 33", busy);
      end
      @(posedge clk); #1;
      vectors++;
      if (mul_if.data_valid_out !== 1'b0 || mul_if.product_out !== 8'sd120) begin
         errors++; $display("FAIL 12x10 pulse/hold: valid %0b product %0d expected 0/120",
                            mul_if.data_valid_out, mul_if.product_out);
      end
   endtask

   task automatic test_overflow();
`ifdef MULTIPLIER_SATURATE_EN
      check_result("12x11", 12, 11, 127, 1'b1);
`else
      check_result("12x11", 12, 11, -124, 1'b1);
`endif
   endtask

   task automatic test_signs();
      int ta[5]  = '{-16, -1, 7, 0, 32'sh80000000};
      int tb[5]  = '{8, -1, -3, 32'sh80000000, 2};
      int tps[5] = '{-128, 1, -21, 0, -128};
      int tpw[5] = '{-128, 1, -21, 0, 0};
      logic tov[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
`ifdef MULTIPLIER_SATURATE_EN
         check_result($sformatf("sign%0d", i), ta[i], tb[i], tps[i], tov[i]);
`else
         check_result($sformatf("sign%0d", i), ta[i], tb[i], tpw[i], tov[i]);
`endif
      end
   endtask

   task automatic test_ignore_busy();
      logic signed [7:0] p;
      logic ovf;
      int lat, busy, cnt;
      bit got;
      start(3, 4);
      wait_result(10, p, ovf, lat, busy, got);
      vectors++;
      if (!got || p !== 8'sd12) begin
         errors++; $display("FAIL ignore product: got %0d (valid %0b) expected 12", p, got);
      end
      count_valids(45, cnt);
      vectors++;
      if (cnt !== 0) begin
         errors++; $display("FAIL ignore extra results: got %0d expected 0", cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic signed [7:0] p;
      logic ovf;
      int lat, busy;
      bit got;
      start(3, 4);
      wait_result(-10, p, ovf, lat, busy, got);
      vectors++;
      if (!got || p !== 8'sd12) begin
         errors++; $display("FAIL b2b first: got %0d (valid %0b) expected 12", p, got);
      end
      start(2, 3);
      wait_result(-10, p, ovf, lat, busy, got);
      vectors++;
      if (!got || p !== 8'sd6) begin
         errors++; $display("FAIL b2b second: got %0d (valid %0b) expected 6", p, got);
      end
      vectors++;
      if (lat !== 34) begin
         errors++; $display("FAIL b2b latency: got %0d expected 34", lat);
      end
   endtask

   task automatic test_reset_mid();
      int cnt;
      start(8, 9);
      repeat (14) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      vectors++;
      if (mul_if.busy_out !== 1'b0 || mul_if.product_out !== 8'sd0 ||
          mul_if.data_valid_out !== 1'b0) begin
         errors++; $display("FAIL midreset outputs: busy %0b product %0d valid %0b expected 0/0/0",
                            mul_if.busy_out, mul_if.product_out, mul_if.data_valid_out);
      end
      count_valids(45, cnt);
      vectors++;
      if (cnt !== 0) begin
         errors++; $display("FAIL midreset stray result: got %0d expected 0", cnt);
      end
      check_result("6x-7", 6, -7, -42, 1'b0);
   endtask

   initial begin
      mul_if.multiplicand_in = '0;
      mul_if.multiplier_in   = '0;
      mul_if.data_valid_in   = 1'b0;
      test_reset();
      test_basic();
      test_overflow();
      test_signs();
      test_ignore_busy();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
